ready_queue_ctrl: RTL and testbench

Sorted ready-queue writer for the hardware scheduler. It accepts task-enqueue requests (task id plus priority) and keeps the queue ordered in a 16-slot shift-register table. The per-slot task ids and valid flags drive the head-select priority mux, where slot 0 is the head. It also services head pops from the dispatcher, removal by task id (kill) and a full flush.

---
 rtl/sched_pkg.sv | 19 +
 rtl/rq_insert_pos.sv | 31 +++
 rtl/ready_queue_ctrl.sv | 133 +++++++++++++
 tb/tb_ready_queue_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared constants and the queue-entry record for the hardware scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sched_pkg;

    localparam int DEPTH  = 16;
    localparam int TID_W  = 4;
    localparam int PRIO_W = 3;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [TID_W-1:0]  tid;
        logic [PRIO_W-1:0] prio;
    } rq_entry_t;

    localparam rq_entry_t EMPTY_ENTRY = '0;

endpackage

// File: rtl/rq_insert_pos.sv
// Insert-position mask for the sorted ready queue: bit i set means slot i is at or after the insert point.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
//
// Ports: slot_prio/slot_valid (current table), enq_prio (incoming priority), ins_mask (thermometer, LSB-first).
module rq_insert_pos
    import sched_pkg::*;
(
    input  logic [DEPTH*PRIO_W-1:0] slot_prio,
    input  logic [DEPTH-1:0]        slot_valid,
    input  logic [PRIO_W-1:0]       enq_prio,
    output logic [DEPTH-1:0]        ins_mask
);

    logic [DEPTH-1:0] gt;
    logic             acc;

    // A slot is "past" the insert point when it is empty or strictly less urgent.
    // The running OR turns that comparator row into a clean thermometer code.
    always_comb begin
        gt       = '0;
        ins_mask = '0;
        acc      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            gt[i]       = !slot_valid[i] || (slot_prio[i*PRIO_W +: PRIO_W] > enq_prio);
            acc         = acc | gt[i];
            ins_mask[i] = acc;
        end
    end

endmodule

// File: rtl/ready_queue_ctrl.sv
// Sorted ready-queue writer: priority-ordered shift-register table with enqueue, head pop, kill-by-id and flush.
// Latency: table/count/full/empty update one cycle after the accepting edge; enq_ready/deq_ack are combinational.
// Backpressure: enq_ready drops when full (unless a pop frees a slot) and during kill or flush cycles.
//
// Ports: clk/rst_n; enq_valid/enq_ready/enq_tid/enq_prio; deq_req/deq_ack; kill_valid/kill_tid/kill_miss;
//        flush; slot_tid/slot_valid (per-slot table view, slot 0 = head); count, full, empty.
module ready_queue_ctrl
    import sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [TID_W-1:0]       enq_tid,
    input  logic [PRIO_W-1:0]      enq_prio,
    input  logic                   deq_req,
    output logic                   deq_ack,
    input  logic                   kill_valid,
    input  logic [TID_W-1:0]       kill_tid,
    output logic                   kill_miss,
    input  logic                   flush,
    output logic [DEPTH*TID_W-1:0] slot_tid,
    output logic [DEPTH-1:0]       slot_valid,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty
);

    rq_entry_t [DEPTH-1:0]   tbl;
    rq_entry_t [DEPTH-1:0]   tbl_nxt;
    rq_entry_t [DEPTH-1:0]   tbl_dn;
    rq_entry_t [DEPTH-1:0]   tbl_up;
    rq_entry_t               new_e;
    logic [DEPTH*PRIO_W-1:0] slot_prio;
    logic [DEPTH-1:0]        ins_mask;
    logic [DEPTH-1:0]        ins_first;
    logic [DEPTH-1:0]        mix_mask;
    logic [DEPTH-1:0]        mix_first;
    logic [DEPTH-1:0]        kill_mask;
    logic                    kill_hit;
    logic                    kill_acc;
    logic                    enq_fire;
    logic [CNT_W-1:0]        count_nxt;

    always_comb begin
        slot_tid   = '0;
        slot_valid = '0;
        slot_prio  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_tid[i*TID_W +: TID_W]    = tbl[i].tid;
            slot_valid[i]                 = tbl[i].valid;
            slot_prio[i*PRIO_W +: PRIO_W] = tbl[i].prio;
        end
    end

    rq_insert_pos u_insert_pos (
        .slot_prio  (slot_prio),
        .slot_valid (slot_valid),
        .enq_prio   (enq_prio),
        .ins_mask   (ins_mask)
    );

    assign new_e  = '{valid: 1'b1, tid: enq_tid, prio: enq_prio};
    assign tbl_dn = {EMPTY_ENTRY, tbl[DEPTH-1:1]};
    assign tbl_up = {tbl[DEPTH-2:0], new_e};

    assign ins_first = ins_mask & ~{ins_mask[DEPTH-2:0], 1'b0};

    // Combined pop+push: the table is viewed after the head shifts out, so the
    // mask moves down one slot. The head is the most urgent entry, so leaving it
    // out of the comparison never moves the insert point below slot 1; with a
    // single entry the shifted mask is all ones and the new entry lands in slot 0.
    assign mix_mask  = {1'b1, ins_mask[DEPTH-1:1]};
    assign mix_first = mix_mask & ~{mix_mask[DEPTH-2:0], 1'b0};

    // Thermometer from the first matching slot upward; duplicates beyond the
    // first are untouched.
    always_comb begin
        kill_mask = '0;
        kill_acc  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_acc     = kill_acc | (tbl[i].valid && (tbl[i].tid == kill_tid));
            kill_mask[i] = kill_acc;
        end
        kill_hit = kill_acc;
    end

    assign deq_ack   = deq_req && !empty && !flush && !kill_valid;
    assign enq_ready = !flush && !kill_valid && (!full || deq_ack);
    assign enq_fire  = enq_valid && enq_ready;

    always_comb begin
        tbl_nxt   = tbl;
        count_nxt = count;
        if (flush) begin
            tbl_nxt   = '0;
            count_nxt = '0;
        end else if (kill_valid) begin
            if (kill_hit) begin
                for (int i = 0; i < DEPTH; i++)
                    tbl_nxt[i] = kill_mask[i] ? tbl_dn[i] : tbl[i];
                count_nxt = count - CNT_W'(1);
            end
        end else if (enq_fire && deq_ack) begin
            for (int i = 0; i < DEPTH; i++)
                tbl_nxt[i] = !mix_mask[i] ? tbl_dn[i] : (mix_first[i] ? new_e : tbl[i]);
        end else if (enq_fire) begin
            for (int i = 0; i < DEPTH; i++)
                tbl_nxt[i] = !ins_mask[i] ? tbl[i] : (ins_first[i] ? new_e : tbl_up[i]);
            count_nxt = count + CNT_W'(1);
        end else if (deq_ack) begin
            tbl_nxt   = tbl_dn;
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl       <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            kill_miss <= 1'b0;
        end else begin
            tbl       <= tbl_nxt;
            count     <= count_nxt;
            full      <= (count_nxt == CNT_W'(DEPTH));
            empty     <= (count_nxt == '0);
            kill_miss <= kill_valid && !flush && !kill_hit;
        end
    end

endmodule

// File: tb/tb_ready_queue_ctrl.sv
// Self-checking bench for ready_queue_ctrl: queue-based reference model plus directed literal checks.
// Latency: model updates at each rising edge; outputs compared on the falling edge.
// Backpressure: model predicts enq_ready/deq_ack from its own occupancy.
module tb_ready_queue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [3:0]  enq_tid = '0;
    logic [2:0]  enq_prio = '0;
    logic        deq_req = 1'b0;
    logic        deq_ack;
    logic        kill_valid = 1'b0;
    logic [3:0]  kill_tid = '0;
    logic        kill_miss;
    logic        flush = 1'b0;
    logic [63:0] slot_tid;
    logic [15:0] slot_valid;
    logic [4:0]  count;
    logic        full;
    logic        empty;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ready_queue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enq_valid  (enq_valid),
        .enq_ready  (enq_ready),
        .enq_tid    (enq_tid),
        .enq_prio   (enq_prio),
        .deq_req    (deq_req),
        .deq_ack    (deq_ack),
        .kill_valid (kill_valid),
        .kill_tid   (kill_tid),
        .kill_miss  (kill_miss),
        .flush      (flush),
        .slot_tid   (slot_tid),
        .slot_valid (slot_valid),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    // ---------------- reference model: an ordered list of (tid, prio) ----------------
    typedef struct {
        logic [3:0] tid;
        logic [2:0] prio;
    } m_ent_t;

    m_ent_t mq[$];
    logic   km_exp = 1'b0;

    function automatic logic exp_deq_ack();
        return deq_req && (mq.size() != 0) && !flush && !kill_valid;
    endfunction

    function automatic logic exp_enq_ready();
        return !flush && !kill_valid && ((mq.size() < 16) || exp_deq_ack());
    endfunction

    function automatic logic [63:0] exp_tid();
        logic [63:0] v = '0;
        for (int k = 0; k < mq.size(); k++) v[k*4 +: 4] = mq[k].tid;
        return v;
    endfunction

    function automatic logic [15:0] exp_valid();
        logic [15:0] v = '0;
        for (int k = 0; k < mq.size(); k++) v[k] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            km_exp = 1'b0;
        end else begin
            logic da, ea;
            int   pos;
            da = exp_deq_ack();
            ea = enq_valid && exp_enq_ready();
            km_exp = 1'b0;
            if (flush) begin
                mq.delete();
            end else if (kill_valid) begin
                pos = -1;
                for (int k = 0; k < mq.size(); k++)
                    if (pos < 0 && mq[k].tid == kill_tid) pos = k;
                if (pos >= 0) mq.delete(pos);
                else          km_exp = 1'b1;
            end else begin
                if (da) void'(mq.pop_front());
                if (ea) begin
                    m_ent_t e;
                    e.tid  = enq_tid;
                    e.prio = enq_prio;
                    pos = mq.size();
                    for (int k = mq.size() - 1; k >= 0; k--)
                        if (mq[k].prio > enq_prio) pos = k;
                    mq.insert(pos, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model slot_tid",   slot_tid,         exp_tid());
            chk("model slot_valid", 64'(slot_valid),  64'(exp_valid()));
            chk("model count",      64'(count),       64'(mq.size()));
            chk("model full",       64'(full),        64'(mq.size() == 16));
            chk("model empty",      64'(empty),       64'(mq.size() == 0));
            chk("model kill_miss",  64'(kill_miss),   64'(km_exp));
            chk("model enq_ready",  64'(enq_ready),   64'(exp_enq_ready()));
            chk("model deq_ack",    64'(deq_ack),     64'(exp_deq_ack()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(input logic ev, input logic [3:0] et, input logic [2:0] ep,
                         input logic dq, input logic kv, input logic [3:0] kt, input logic fl);
        @(posedge clk);
        #1;
        enq_valid  = ev;
        enq_tid    = et;
        enq_prio   = ep;
        deq_req    = dq;
        kill_valid = kv;
        kill_tid   = kt;
        flush      = fl;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        logic [11:0] lo12;
        logic [7:0]  lo8;

        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        chk("reset slot_valid", 64'(slot_valid), 64'h0);
        chk("reset slot_tid",   slot_tid,        64'h0);
        chk("reset count",      64'(count),      64'd0);
        chk("reset empty",      64'(empty),      64'd1);
        chk("reset full",       64'(full),       64'd0);
        chk("reset kill_miss",  64'(kill_miss),  64'd0);
        chk("reset enq_ready",  64'(enq_ready),  64'd1);
        chk("reset deq_ack",    64'(deq_ack),    64'd0);

        // Ordered insert with FIFO among equal priorities
        apply(1'b1, 4'd5, 3'd3, 1'b0, 1'b0, 4'd0, 1'b0);
        apply(1'b1, 4'd2, 3'd1, 1'b0, 1'b0, 4'd0, 1'b0);
        apply(1'b1, 4'd9, 3'd3, 1'b0, 1'b0, 4'd0, 1'b0);
        idle();
        lo12 = slot_tid[11:0];
        chk("order tids", 64'(lo12),  64'h952);
        chk("order count", 64'(count), 64'd3);
        chk("order empty", 64'(empty), 64'd0);

        // Kill hit, then kill miss
        apply(1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 4'd5, 1'b0);
        idle();
        lo8 = slot_tid[7:0];
        chk("kill tids",  64'(lo8),   64'h92);
        chk("kill count", 64'(count), 64'd2);
        apply(1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 4'd4, 1'b0);
        idle();
        lo8 = slot_tid[7:0];
        chk("kill miss pulse", 64'(kill_miss), 64'd1);
        chk("kill miss tids",  64'(lo8),       64'h92);
        idle();
        chk("kill miss end",   64'(kill_miss), 64'd0);
        chk("kill miss count", 64'(count),     64'd2);

        // Flush beats concurrent enq and deq
        apply(1'b1, 4'd1, 3'd1, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("flush enq_ready", 64'(enq_ready), 64'd0);
        chk("flush deq_ack",   64'(deq_ack),   64'd0);
        idle();
        chk("flush count", 64'(count), 64'd0);
        chk("flush empty", 64'(empty), 64'd1);

        // Pop on empty queue
        apply(1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("deq empty ack", 64'(deq_ack), 64'd0);
        idle();
        chk("deq empty count", 64'(count),      64'd0);
        chk("deq empty valid", 64'(slot_valid), 64'h0);

        // Fill to 16 with priorities 1..7
        for (int i = 0; i < 16; i++)
            apply(1'b1, 4'(i), 3'(1 + i % 7), 1'b0, 1'b0, 4'd0, 1'b0);
        idle();
        chk("fill full",      64'(full),      64'd1);
        chk("fill enq_ready", 64'(enq_ready), 64'd0);
        apply(1'b1, 4'd7, 3'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("full swap deq_ack",   64'(deq_ack),   64'd1);
        chk("full swap enq_ready", 64'(enq_ready), 64'd1);
        idle();
        chk("full swap head", 64'(slot_tid[3:0]), 64'd7);
        chk("full swap count", 64'(count),        64'd16);

        // Mixed traffic against the model
        apply(1'b1, 4'd3, 3'd5, 1'b1, 1'b0, 4'd0, 1'b0);
        apply(1'b1, 4'd12, 3'd2, 1'b1, 1'b0, 4'd0, 1'b0);
        apply(1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        apply(1'b1, 4'd14, 3'd7, 1'b0, 1'b1, 4'd10, 1'b0);
        apply(1'b1, 4'd14, 3'd7, 1'b0, 1'b0, 4'd0, 1'b0);
        apply(1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 4'd14, 1'b0);
        apply(1'b1, 4'd6, 3'd4, 1'b1, 1'b0, 4'd0, 1'b0);
        idle();

        // Pop + push with a single entry lands in slot 0
        apply(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        apply(1'b1, 4'd3, 3'd4, 1'b0, 1'b0, 4'd0, 1'b0);
        apply(1'b1, 4'd6, 3'd2, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("one swap deq_ack", 64'(deq_ack), 64'd1);
        idle();
        chk("one swap head",  64'(slot_tid[3:0]), 64'd6);
        chk("one swap count", 64'(count),         64'd1);

        // Asynchronous reset mid-burst
        apply(1'b1, 4'd1, 3'd2, 1'b0, 1'b0, 4'd0, 1'b0);
        apply(1'b1, 4'd4, 3'd6, 1'b0, 1'b0, 4'd0, 1'b0);
        @(posedge clk);
        #3;
        enq_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("async reset valid", 64'(slot_valid), 64'h0);
        chk("async reset count", 64'(count),      64'd0);
        chk("async reset empty", 64'(empty),      64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(1'b1, 4'd11, 3'd5, 1'b0, 1'b0, 4'd0, 1'b0);
        idle();
        chk("post reset head",  64'(slot_tid[3:0]), 64'd11);
        chk("post reset valid", 64'(slot_valid),    64'h1);

        idle();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
